rvc_asap_5pl_vga_raster: RTL and testbench

Raster engine for the rvc_asap_5pl VGA path. Sits directly downstream of the VGA memory inside the VGA controller. Generates 640x480@60 Hz timing from the core Clock, prefetches 1-bpp pixel words from the VGA memory read port, and serialises them to the RED/GREEN/BLUE and h_sync/v_sync pins of rvc_top_5pl.

---
 rtl/rvc_asap_pkg.sv | 36 +++
 rtl/rvc_asap_5pl_vga_timing.sv | 88 ++++++++
 rtl/rvc_asap_5pl_vga_raster.sv | 206 ++++++++++++++++++++
 tb/tb_rvc_asap_5pl_vga_raster.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_asap_pkg.sv
// -----------------------------------------------------------------------------
// rvc_asap_pkg
// Shared constants and types for the rvc_asap_5pl VGA raster path.
//   - 640x480@60 Hz timing constants (pixels / lines)
//   - VGA memory geometry (80 words per 4-row band, 9600 words total)
//   - t_rgb12 : packed {r,g,b} 4-bit colour triple
//   - vga_word_addr() : (row, group) -> VGA memory word index
// -----------------------------------------------------------------------------
package rvc_asap_pkg;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;

   localparam int VGA_WORDS_PER_LINE = 80;
   localparam int VGA_MEM_WORDS      = 9600;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } t_rgb12;

   // Four consecutive rows share one word (one byte lane each), so the word
   // index only depends on row/4.
   function automatic logic [13:0] vga_word_addr(input logic [9:0] row,
                                                  input logic [6:0] grp);
      return 14'(row[9:2]) * 14'(VGA_WORDS_PER_LINE) + 14'(grp);
   endfunction

endpackage

// File: rtl/rvc_asap_5pl_vga_timing.sv
// -----------------------------------------------------------------------------
// rvc_asap_5pl_vga_timing
// Pixel-rate tick and horizontal/vertical counters for the VGA raster.
// Ports:
//   clock_i     core clock
//   rst_i       asynchronous active-high reset
//   pix_tick_o  high every other clock; counters advance on the edge it is high
//   hcnt_o      horizontal pixel counter 0..H_TOT-1
//   vcnt_o      vertical line counter 0..V_TOT-1
//   visible_o   current (hcnt,vcnt) lies in the active picture
//   hsync_n_o   raw horizontal sync, active-low, combinational from hcnt
//   vsync_n_o   raw vertical sync, active-low, combinational from vcnt
// Reset puts the counters 8 pixels before the end of the last line so the
// group-0 fetch for line 0 is issued by the normal fetch rule.
// -----------------------------------------------------------------------------
module rvc_asap_5pl_vga_timing
   import rvc_asap_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
) (
   input  logic       clock_i,
   input  logic       rst_i,
   output logic       pix_tick_o,
   output logic [9:0] hcnt_o,
   output logic [9:0] vcnt_o,
   output logic       visible_o,
   output logic       hsync_n_o,
   output logic       vsync_n_o
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_RST   = 10'(H_TOT - 8);
   localparam logic [9:0] H_VIS_C = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   logic       tick_q, tick_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;

   always_comb begin
      tick_d = ~tick_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (tick_q) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock_i or posedge rst_i) begin
      if (rst_i) begin
         tick_q <= 1'b0;
         hcnt_q <= H_RST;
         vcnt_q <= V_LAST;
      end else begin
         tick_q <= tick_d;
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign pix_tick_o = tick_q;
   assign hcnt_o     = hcnt_q;
   assign vcnt_o     = vcnt_q;
   assign visible_o  = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
   assign hsync_n_o  = ~((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
   assign vsync_n_o  = ~((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

endmodule

// File: rtl/rvc_asap_5pl_vga_raster.sv
// -----------------------------------------------------------------------------
// rvc_asap_5pl_vga_raster
// 640x480@60 Hz raster engine: generates timing, prefetches 1-bpp pixel words
// from the VGA memory and serialises them to the RGB / sync pins.
// Ports:
//   Clock, Rst         core clock, asynchronous active-high reset
//   RdEn, RdWordAddr   one-clock read strobe and word index into VGA memory
//   RdData             read data, valid the clock after RdEn
//   FgColor, BgColor   foreground / background colour (only with
//                      RVC_VGA_COLOR_EN defined)
//   RED, GREEN, BLUE   4-bit colour channels, 0 during blanking
//   h_sync, v_sync     active-low syncs, aligned with RGB
// Optional feature macro: RVC_VGA_COLOR_EN. When undefined a lit pixel is
// 4'hF on every channel and an unlit pixel is black.
// -----------------------------------------------------------------------------
module rvc_asap_5pl_vga_raster
   import rvc_asap_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
) (
   input  logic        Clock,
   input  logic        Rst,
   output logic        RdEn,
   output logic [13:0] RdWordAddr,
   input  logic [31:0] RdData,
`ifdef RVC_VGA_COLOR_EN
   input  logic [11:0] FgColor,
   input  logic [11:0] BgColor,
`endif
   output logic [3:0]  RED,
   output logic [3:0]  GREEN,
   output logic [3:0]  BLUE,
   output logic        h_sync,
   output logic        v_sync
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_PRE   = 10'(H_TOT - 8);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [6:0] GRP_LIM = 7'(H_VIS / 8);

   logic       pix_tick;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       visible;
   logic       hsync_n;
   logic       vsync_n;

   rvc_asap_5pl_vga_timing #(
      .H_VIS (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_VIS (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clock_i    (Clock),
      .rst_i      (Rst),
      .pix_tick_o (pix_tick),
      .hcnt_o     (hcnt),
      .vcnt_o     (vcnt),
      .visible_o  (visible),
      .hsync_n_o  (hsync_n),
      .vsync_n_o  (vsync_n)
   );

   logic [11:0] on_col;
   logic [11:0] off_col;
`ifdef RVC_VGA_COLOR_EN
   assign on_col  = FgColor;
   assign off_col = BgColor;
`else
   assign on_col  = 12'hFFF;
   assign off_col = 12'h000;
`endif

   logic        rd_en_q,     rd_en_d;
   logic [13:0] rd_addr_q,   rd_addr_d;
   logic [1:0]  lane_q,      lane_d;
   logic        rd_pend_q,   rd_pend_d;
   logic [7:0]  next_byte_q, next_byte_d;
   logic        next_vld_q,  next_vld_d;
   logic [7:0]  shift_q,     shift_d;
   logic        vis_p0_q,    vis_p0_d;
   logic        hs_p0_q,     hs_p0_d;
   logic        vs_p0_q,     vs_p0_d;
   t_rgb12      rgb_q,       rgb_d;
   logic        hs_q,        hs_d;
   logic        vs_q,        vs_d;

   logic [6:0]  grp;
   logic [9:0]  row;
   logic        fetch;

   // Fetch request: one group ahead within the line, group 0 of the next line
   // eight pixels before the line wraps.
   always_comb begin
      grp   = hcnt[9:3] + 7'd1;
      row   = vcnt;
      fetch = 1'b0;
      if (pix_tick) begin
         if (hcnt == H_PRE) begin
            grp   = '0;
            row   = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            fetch = 1'b1;
         end else if ((hcnt[2:0] == 3'd0) && (grp < GRP_LIM)) begin
            fetch = 1'b1;
         end
      end
      if (row >= V_VIS_C) begin
         fetch = 1'b0;
      end
   end

   always_comb begin
      rd_en_d     = fetch;
      rd_addr_d   = fetch ? vga_word_addr(row, grp) : rd_addr_q;
      lane_d      = fetch ? row[1:0] : lane_q;
      rd_pend_d   = rd_en_q;
      next_byte_d = next_byte_q;
      next_vld_d  = next_vld_q;
      shift_d     = shift_q;
      vis_p0_d    = vis_p0_q;
      hs_p0_d     = hs_p0_q;
      vs_p0_d     = vs_p0_q;
      rgb_d       = rgb_q;
      hs_d        = hs_q;
      vs_d        = vs_q;

      // Read data arrives now: keep only the byte lane of the requested row.
      if (rd_pend_q) begin
         next_byte_d = RdData[{lane_q, 3'b000} +: 8];
         next_vld_d  = 1'b1;
      end

      // Stage p0 (pixel tick): shifter presents the pixel for hcnt/vcnt,
      // flags sampled from the same counter values.
      if (pix_tick) begin
         if (visible) begin
            if (hcnt[2:0] == 3'd0) begin
               shift_d = next_vld_q ? next_byte_q : 8'h00;
               if (!rd_pend_q) begin
                  next_vld_d = 1'b0;
               end
            end else begin
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         vis_p0_d = visible;
         hs_p0_d  = hsync_n;
         vs_p0_d  = vsync_n;
      end else begin
         // Stage p1 (between ticks): colour/sync output register.
         rgb_d = vis_p0_q ? (shift_q[0] ? on_col : off_col) : 12'h000;
         hs_d  = hs_p0_q;
         vs_d  = vs_p0_q;
      end
   end

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         lane_q      <= '0;
         rd_pend_q   <= 1'b0;
         next_byte_q <= '0;
         next_vld_q  <= 1'b0;
         shift_q     <= '0;
         vis_p0_q    <= 1'b0;
         hs_p0_q     <= 1'b1;
         vs_p0_q     <= 1'b1;
         rgb_q       <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
      end else begin
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         lane_q      <= lane_d;
         rd_pend_q   <= rd_pend_d;
         next_byte_q <= next_byte_d;
         next_vld_q  <= next_vld_d;
         shift_q     <= shift_d;
         vis_p0_q    <= vis_p0_d;
         hs_p0_q     <= hs_p0_d;
         vs_p0_q     <= vs_p0_d;
         rgb_q       <= rgb_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
      end
   end

   assign RdEn       = rd_en_q;
   assign RdWordAddr = rd_addr_q;
   assign RED        = rgb_q.r;
   assign GREEN      = rgb_q.g;
   assign BLUE       = rgb_q.b;
   assign h_sync     = hs_q;
   assign v_sync     = vs_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_raster.sv
// -----------------------------------------------------------------------------
// Testbench for rvc_asap_5pl_vga_raster. The raster is instantiated with a
// reduced timing geometry (64x8 visible, 96x15 total) so whole frames fit in a
// short run; every expectation is derived from these parameters.
// -----------------------------------------------------------------------------
module tb_rvc_asap_5pl_vga_raster;

   localparam int HV = 64, HF = 8, HS = 16, HB = 8;
   localparam int VV = 8,  VF = 2, VS = 2,  VB = 3;
   localparam int HT      = HV + HF + HS + HB;
   localparam int VT      = VV + VF + VS + VB;
   localparam int FRAME   = HT * VT;
   localparam int START   = (VT - 1) * HT + HT - 8;
   localparam int CAP_END = 2 * (2 * FRAME - START) + 1;
   localparam int RUN_END = 2 * (2 * FRAME + 13 * HT - START);

   logic        Clock = 1'b0;
   logic        Rst;
   logic        RdEn;
   logic [13:0] RdWordAddr;
   logic [31:0] RdData = '0;
   logic [3:0]  RED, GREEN, BLUE;
   logic        h_sync, v_sync;

`ifdef RVC_VGA_COLOR_EN
   logic [11:0] FgColor = 12'hF00;
   logic [11:0] BgColor = 12'h00F;
   localparam logic [11:0] ON  = 12'hF00;
   localparam logic [11:0] OFF = 12'h00F;
`else
   localparam logic [11:0] ON  = 12'hFFF;
   localparam logic [11:0] OFF = 12'h000;
`endif

   always #5 Clock = ~Clock;

   rvc_asap_5pl_vga_raster #(
      .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .Clock      (Clock),
      .Rst        (Rst),
      .RdEn       (RdEn),
      .RdWordAddr (RdWordAddr),
      .RdData     (RdData),
`ifdef RVC_VGA_COLOR_EN
      .FgColor    (FgColor),
      .BgColor    (BgColor),
`endif
      .RED        (RED),
      .GREEN      (GREEN),
      .BLUE       (BLUE),
      .h_sync     (h_sync),
      .v_sync     (v_sync)
   );

   // VGA memory: one clock read latency
   logic [31:0] mem [0:9599];
   always @(posedge Clock) begin
      if (RdEn) RdData <= mem[RdWordAddr];
   end

   // Clocks since reset release
   int ecnt;
   always @(posedge Clock or posedge Rst) begin
      if (Rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   // Raster position (linear, from reset start point) shown at odd sample e
   function automatic int labs_of(input int e);
      return START + (e - 1) / 2 - 1;
   endfunction

   function automatic logic [11:0] exp_rgb(input int x, input int y);
      logic [31:0] w;
      if (x >= HV || y >= VV) return 12'h000;
      w = mem[(y / 4) * 80 + x / 8];
      return w[8 * (y % 4) + x % 8] ? ON : OFF;
   endfunction

   function automatic logic exp_hs(input int x);
      return !(x >= HV + HF && x < HV + HF + HS);
   endfunction

   function automatic logic exp_vs(input int y);
      return !(y >= VV + VF && y < VV + VF + VS);
   endfunction

   // Continuous monitor
   int          pix_bad, sync_bad, hold_bad, rd_gap_bad;
   int          hfall, hper, hlow, vfall, vper, vlow, last_rd;
   logic        prev_hs, prev_vs;
   logic [13:0] prev_out;
   logic [11:0] obs [0:VV-1][0:HV-1];
   int          rdq[$];
   int          mon_l, mon_x, mon_y;
   logic [11:0] mon_cur;

   always @(negedge Clock) begin
      if (Rst) begin
         pix_bad = 0; sync_bad = 0; hold_bad = 0; rd_gap_bad = 0;
         hfall = 0; hper = 0; hlow = 0; vfall = 0; vper = 0; vlow = 0;
         last_rd = 0; prev_hs = 1'b1; prev_vs = 1'b1; prev_out = '0;
         rdq.delete();
         for (int yy = 0; yy < VV; yy++)
            for (int xx = 0; xx < HV; xx++)
               obs[yy][xx] = 12'hABC;
      end else if (ecnt >= 1) begin
         mon_cur = {RED, GREEN, BLUE};
         if (ecnt % 2 == 1 && ecnt >= 3) begin
            mon_l = labs_of(ecnt);
            mon_x = mon_l % HT;
            mon_y = (mon_l / HT) % VT;
            if (mon_cur !== exp_rgb(mon_x, mon_y)) pix_bad++;
            if (h_sync !== exp_hs(mon_x) || v_sync !== exp_vs(mon_y)) sync_bad++;
            if (mon_x < HV && mon_y < VV && mon_l / FRAME == 1)
               obs[mon_y][mon_x] = mon_cur;
            prev_out = {mon_cur, h_sync, v_sync};
         end else if (ecnt >= 4) begin
            if ({mon_cur, h_sync, v_sync} !== prev_out) hold_bad++;
         end
         if (prev_hs && !h_sync) begin
            if (hfall > 0) hper = ecnt - hfall;
            hfall = ecnt;
         end
         if (!prev_hs && h_sync && hfall > 0) hlow = ecnt - hfall;
         if (prev_vs && !v_sync) begin
            if (vfall > 0) vper = ecnt - vfall;
            vfall = ecnt;
         end
         if (!prev_vs && v_sync && vfall > 0) vlow = ecnt - vfall;
         prev_hs = h_sync;
         prev_vs = v_sync;
         if (RdEn === 1'b1) begin
            if (last_rd > 0 && ecnt - last_rd < 16) rd_gap_bad++;
            last_rd = ecnt;
            if (ecnt <= CAP_END) rdq.push_back(int'(RdWordAddr));
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ecnt(input int target);
      int n;
      n = 0;
      while (ecnt < target && n < 20000) begin
         @(negedge Clock);
         n++;
      end
      check("wait_ecnt", (ecnt >= target) ? 1 : 0, 1);
   endtask

   task automatic release_and_first_fetch(input string tag);
      @(negedge Clock);
      Rst = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      check({tag, "_rden_clk1"}, RdEn, 0);
      @(posedge Clock);
      @(negedge Clock);
      check({tag, "_rden_clk2"}, RdEn, 1);
      check({tag, "_addr_clk2"}, RdWordAddr, 0);
   endtask

   typedef struct {
      int          x;
      int          y;
      logic [11:0] rgb;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic check_frame(input string tag);
      int bad;
      for (int i = 0; i < NV; i++)
         check($sformatf("%s_pix(%0d,%0d)", tag, tbl[i].x, tbl[i].y),
               obs[tbl[i].y][tbl[i].x], tbl[i].rgb);
      check({tag, "_pix_model_errs"}, pix_bad, 0);
      check({tag, "_sync_model_errs"}, sync_bad, 0);
      check({tag, "_hold2_errs"}, hold_bad, 0);
      check({tag, "_rden_gap_errs"}, rd_gap_bad, 0);
      check({tag, "_fetch_count"}, rdq.size(), 65);
      if (rdq.size() >= 65) begin
         bad = 0;
         for (int i = 0; i < 64; i++)
            if (rdq[i] != ((i / 8) / 4) * 80 + (i % 8)) bad++;
         if (rdq[64] != 0) bad++;
         check({tag, "_fetch_seq_errs"}, bad, 0);
         check({tag, "_fetch_row5_grp1"}, rdq[41], 81);
      end
   endtask

   initial begin : main
      bit found;
      tbl[0]  = '{0, 0, ON};   tbl[1]  = '{1, 0, OFF};  tbl[2]  = '{0, 1, OFF};
      tbl[3]  = '{7, 0, OFF};  tbl[4]  = '{15, 5, ON};  tbl[5]  = '{14, 5, OFF};
      tbl[6]  = '{15, 4, OFF}; tbl[7]  = '{15, 6, OFF}; tbl[8]  = '{8, 5, OFF};
      tbl[9]  = '{16, 3, ON};  tbl[10] = '{17, 3, OFF}; tbl[11] = '{18, 3, ON};
      tbl[12] = '{20, 3, OFF}; tbl[13] = '{21, 3, ON};  tbl[14] = '{22, 3, OFF};
      tbl[15] = '{23, 3, ON};  tbl[16] = '{63, 7, ON};  tbl[17] = '{62, 7, OFF};
      tbl[18] = '{0, 4, OFF};

      for (int i = 0; i < 9600; i++) mem[i] = '0;
      mem[0]  = 32'h0000_0001;   // pixel (0,0)
      mem[81] = 32'h0000_8000;   // row 5 lane 1, bit 7 -> pixel (15,5)
      mem[2]  = 32'hA500_0000;   // row 3, x 16..23 = 1,0,1,0,0,1,0,1
      mem[87] = 32'h8000_0000;   // pixel (63,7)

      Rst = 1'b1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("rst_rgb", {RED, GREEN, BLUE}, 0);
      check("rst_hsync", h_sync, 1);
      check("rst_vsync", v_sync, 1);
      check("rst_rden", RdEn, 0);

      release_and_first_fetch("run1");
      wait_ecnt(RUN_END);
      check_frame("run1");
      check("hsync_period", hper, 2 * HT);
      check("hsync_low", hlow, 2 * HS);
      check("vsync_period", vper, 2 * FRAME);
      check("vsync_low", vlow, 2 * VS * HT);

      // Reset in the middle of line 5, right at the lit pixel (15,5)
      found = 0;
      for (int n = 0; n < 4000 && !found; n++) begin
         @(negedge Clock);
         if (ecnt % 2 == 1 && labs_of(ecnt) % FRAME == 5 * HT + 15) found = 1;
      end
      check("midrst_point_found", found, 1);
      check("midrst_pre_pix", {RED, GREEN, BLUE}, ON);
      #1 Rst = 1'b1;
      #1;
      check("midrst_rgb", {RED, GREEN, BLUE}, 0);
      check("midrst_hsync", h_sync, 1);
      check("midrst_vsync", v_sync, 1);
      check("midrst_rden", RdEn, 0);
      repeat (3) @(posedge Clock);

      release_and_first_fetch("run2");
      wait_ecnt(CAP_END + 2);
      check_frame("run2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
